flit_sink_ctrl: RTL and testbench

- Parametrised, synthesizable traffic sink for router testbenches and on-chip loopback.
- Sits behind rtr_channel_input on a router output port. Accepts decoded flits for num_vcs VCs and tracks per-VC buffer occupancy.
- Drains flits at an LFSR-throttled rate with round-robin VC selection, and returns credits in the codebase credit format {valid, vc_idx}.
- Adds per-VC packet-protocol checking, sticky error reporting and clearable flit/packet statistics counters.

---
 rtl/flit_sink_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_flit_sink_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_sink_ctrl.sv
// flit_sink_ctrl: traffic sink for one router output port.
// Tracks per-VC buffer occupancy, drains flits at an LFSR-throttled rate with
// round-robin VC selection, and returns credits as {valid, vc_idx}. Also checks
// the per-VC head/body/tail protocol, keeps sticky error flags and keeps
// clearable flit/packet counters.
//
// Optional feature: define FLIT_SINK_CTRL_LEN_CHECK_EN to build per-VC payload
// length checking (error_type_out[3]); without it error_type_out[3] stays 0.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            drain enable (no pops and no credits when low)
//   flit_valid_in     flit present this cycle
//   flit_head_in      head flit
//   flit_tail_in      tail flit (head+tail = single-flit packet)
//   flit_sel_in_ivc   one-hot target VC
//   clear_stats       synchronous clear of counters and error flags
//   flow_ctrl_out     registered credit {valid, vc index}
//   empty_out_ivc     per-VC occupancy == 0
//   flit_count_out    flits popped (saturating)
//   pkt_count_out     tails accepted (saturating)
//   error_out_ivc     sticky per-VC error
//   error_type_out    sticky error kinds: [0] overflow, [1] head in packet,
//                     [2] body outside packet, [3] payload length
module flit_sink_ctrl #(
    parameter int unsigned num_vcs            = 8,
    parameter int unsigned buffer_size        = 64,
    parameter int unsigned consume_rate       = 256,
    parameter logic [15:0] lfsr_seed          = 16'hACE1,
    parameter int unsigned stat_width         = 32,
    parameter int unsigned max_payload_length = 4,
    parameter int unsigned min_payload_length = 0,
    localparam int unsigned vc_idx_width      = (num_vcs > 1) ? $clog2(num_vcs) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flit_valid_in,
    input  logic                    flit_head_in,
    input  logic                    flit_tail_in,
    input  logic [num_vcs-1:0]      flit_sel_in_ivc,
    input  logic                    clear_stats,
    output logic [vc_idx_width:0]   flow_ctrl_out,
    output logic [num_vcs-1:0]      empty_out_ivc,
    output logic [stat_width-1:0]   flit_count_out,
    output logic [stat_width-1:0]   pkt_count_out,
    output logic [num_vcs-1:0]      error_out_ivc,
    output logic [3:0]              error_type_out
);

    localparam int unsigned depth     = buffer_size / num_vcs;
    localparam int unsigned occ_width = $clog2(depth + 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] lfsr_init = (lfsr_seed == 16'd0) ? 16'd1 : lfsr_seed;

    // Elaboration-time parameter sanity check.
    if (depth < 1 || (buffer_size % num_vcs) != 0 || consume_rate > 256 ||
        min_payload_length > max_payload_length || stat_width < 1) begin : g_bad_params
        $error("flit_sink_ctrl: invalid parameter combination");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    logic [occ_width-1:0]    occ_q [num_vcs];
    logic [occ_width-1:0]    occ_d [num_vcs];
    logic [15:0]             lfsr_q;
    logic                    lfsr_fb_c;
    logic                    consume_c;
    logic [vc_idx_width-1:0] rr_ptr_q;
    logic                    grant_valid_c;
    logic [vc_idx_width-1:0] grant_idx_c;
    logic [num_vcs-1:0]      push_c;
    logic [num_vcs-1:0]      pop_c;
    logic [num_vcs-1:0]      ovf_c;
    pkt_state_e              state_q [num_vcs];
    pkt_state_e              state_d [num_vcs];
    logic [num_vcs-1:0]      pkt_done_c;
    logic [num_vcs-1:0]      err_head_c;
    logic [num_vcs-1:0]      err_body_c;
    logic [num_vcs-1:0]      err_len_c;

    // Throttle: Fibonacci LFSR, taps 16,14,13,11; 9-bit compare so rate 256 always drains.
    assign lfsr_fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign consume_c = ({1'b0, lfsr_q[7:0]} < 9'(consume_rate));

    assign push_c = flit_valid_in ? flit_sel_in_ivc : '0;

    // Round-robin grant: rr_ptr_q holds the first VC to try (one past the last grant).
    // Eligibility uses registered empty flags, so a flit pushed this cycle cannot pop.
    always_comb begin
        logic [vc_idx_width-1:0] cand;
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand          = '0;
        if (enable && consume_c) begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                cand = vc_idx_width'((32'(rr_ptr_q) + i) % num_vcs);
                if (!grant_valid_c && !empty_out_ivc[cand]) begin
                    grant_valid_c = 1'b1;
                    grant_idx_c   = cand;
                end
            end
        end
    end

    // Occupancy next-state; a same-cycle push and pop cancel out.
    always_comb begin
        for (int unsigned i = 0; i < num_vcs; i++) begin
            pop_c[i] = grant_valid_c && (grant_idx_c == vc_idx_width'(i));
            occ_d[i] = occ_q[i];
            ovf_c[i] = 1'b0;
            if (push_c[i] && !pop_c[i]) begin
                if (occ_q[i] == occ_width'(depth)) begin
                    ovf_c[i] = 1'b1;
                end else begin
                    occ_d[i] = occ_q[i] + occ_width'(1);
                end
            end else if (!push_c[i] && pop_c[i]) begin
                occ_d[i] = occ_q[i] - occ_width'(1);
            end
        end
    end

    // Occupancy, LFSR, arbiter pointer and credit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                occ_q[i] <= '0;
            end
            empty_out_ivc <= '1;
            lfsr_q        <= lfsr_init;
            rr_ptr_q      <= '0;
            flow_ctrl_out <= '0;
        end else begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                occ_q[i]         <= occ_d[i];
                empty_out_ivc[i] <= (occ_d[i] == '0);
            end
            lfsr_q <= {lfsr_q[14:0], lfsr_fb_c};
            if (grant_valid_c) begin
                rr_ptr_q      <= vc_idx_width'((32'(grant_idx_c) + 32'd1) % num_vcs);
                flow_ctrl_out <= {1'b1, grant_idx_c};
            end else begin
                flow_ctrl_out <= '0;
            end
        end
    end

    // Packet FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Packet FSM: next state. A head inside a packet restarts the packet.
    always_comb begin
        for (int unsigned i = 0; i < num_vcs; i++) begin
            state_d[i] = state_q[i];
            if (push_c[i]) begin
                case (state_q[i])
                    ST_IDLE:   if (flit_head_in && !flit_tail_in) state_d[i] = ST_IN_PKT;
                    ST_IN_PKT: if (flit_tail_in) state_d[i] = ST_IDLE;
                    default:   state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Packet FSM: protocol events. Stray non-head flits in IDLE never count as packets.
    always_comb begin
        for (int unsigned i = 0; i < num_vcs; i++) begin
            pkt_done_c[i] = 1'b0;
            err_head_c[i] = 1'b0;
            err_body_c[i] = 1'b0;
            if (push_c[i]) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (!flit_head_in) begin
                            err_body_c[i] = 1'b1;
                        end else if (flit_tail_in) begin
                            pkt_done_c[i] = 1'b1;
                        end
                    end
                    ST_IN_PKT: begin
                        err_head_c[i] = flit_head_in;
                        pkt_done_c[i] = flit_tail_in;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FLIT_SINK_CTRL_LEN_CHECK_EN
    localparam int unsigned pay_width = $clog2(max_payload_length + 2);
    // Counter saturates one past the maximum; reaching it flags the packet once.
    localparam logic [pay_width-1:0] pay_limit = pay_width'(max_payload_length + 1);

    logic [pay_width-1:0] pay_q [num_vcs];
    logic [pay_width-1:0] pay_d [num_vcs];

    // Payload = non-head flits of the current packet, tail included.
    always_comb begin
        logic [pay_width-1:0] pay_new;
        logic                 in_pkt;
        logic                 flagged;
        pay_new = '0;
        in_pkt  = 1'b0;
        flagged = 1'b0;
        for (int unsigned i = 0; i < num_vcs; i++) begin
            pay_d[i]     = pay_q[i];
            err_len_c[i] = 1'b0;
            in_pkt       = (state_q[i] == ST_IN_PKT);
            flagged      = in_pkt && !flit_head_in && (pay_q[i] == pay_limit);
            if (push_c[i] && (flit_head_in || in_pkt)) begin
                if (flit_head_in) begin
                    pay_new = '0;
                end else if (pay_q[i] == pay_limit) begin
                    pay_new = pay_q[i];
                end else begin
                    pay_new = pay_q[i] + pay_width'(1);
                end
                pay_d[i] = pay_new;
                if (flit_tail_in) begin
                    err_len_c[i] = !flagged &&
                        (((32'(pay_new) + 32'd1) <= min_payload_length) ||
                         (32'(pay_new) > max_payload_length));
                end else begin
                    err_len_c[i] = !flagged && (pay_new == pay_limit);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < num_vcs; i++) begin
                pay_q[i] <= pay_d[i];
            end
        end
    end
`else
    assign err_len_c = '0;
`endif

    // Statistics and sticky errors; clear_stats wins over same-cycle updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_count_out <= '0;
            pkt_count_out  <= '0;
            error_out_ivc  <= '0;
            error_type_out <= '0;
        end else if (clear_stats) begin
            flit_count_out <= '0;
            pkt_count_out  <= '0;
            error_out_ivc  <= '0;
            error_type_out <= '0;
        end else begin
            if (grant_valid_c && (flit_count_out != '1)) begin
                flit_count_out <= flit_count_out + stat_width'(1);
            end
            if ((|pkt_done_c) && (pkt_count_out != '1)) begin
                pkt_count_out <= pkt_count_out + stat_width'(1);
            end
            error_type_out <= error_type_out |
                              {|err_len_c, |err_head_c, |err_body_c, |ovf_c};
            error_out_ivc  <= error_out_ivc | ovf_c | err_head_c | err_body_c | err_len_c;
        end
    end

endmodule

// File: tb/tb_flit_sink_ctrl.sv
module tb_flit_sink_ctrl;

    localparam int unsigned NV    = 8;
    localparam int unsigned VW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SW    = 32;
    localparam int unsigned MAXP  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flit_valid_in;
    logic          flit_head_in;
    logic          flit_tail_in;
    logic [NV-1:0] flit_sel_in_ivc;
    logic          clear_stats;

    logic [VW:0]   fc_full, fc_zero, fc_half;
    logic [NV-1:0] empty_full, empty_zero, empty_half;
    logic [SW-1:0] flits_full, flits_zero, flits_half;
    logic [SW-1:0] pkts_full, pkts_zero, pkts_half;
    logic [NV-1:0] eivc_full, eivc_zero, eivc_half;
    logic [3:0]    etype_full, etype_zero, etype_half;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flit_sink_ctrl #(.consume_rate(256)) u_full (
        .clk(clk), .reset(reset), .enable(enable), .flit_valid_in(flit_valid_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in),
        .flit_sel_in_ivc(flit_sel_in_ivc), .clear_stats(clear_stats),
        .flow_ctrl_out(fc_full), .empty_out_ivc(empty_full), .flit_count_out(flits_full),
        .pkt_count_out(pkts_full), .error_out_ivc(eivc_full), .error_type_out(etype_full));

    flit_sink_ctrl #(.consume_rate(0)) u_zero (
        .clk(clk), .reset(reset), .enable(enable), .flit_valid_in(flit_valid_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in),
        .flit_sel_in_ivc(flit_sel_in_ivc), .clear_stats(clear_stats),
        .flow_ctrl_out(fc_zero), .empty_out_ivc(empty_zero), .flit_count_out(flits_zero),
        .pkt_count_out(pkts_zero), .error_out_ivc(eivc_zero), .error_type_out(etype_zero));

    flit_sink_ctrl #(.consume_rate(128)) u_half (
        .clk(clk), .reset(reset), .enable(enable), .flit_valid_in(flit_valid_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in),
        .flit_sel_in_ivc(flit_sel_in_ivc), .clear_stats(clear_stats),
        .flow_ctrl_out(fc_half), .empty_out_ivc(empty_half), .flit_count_out(flits_half),
        .pkt_count_out(pkts_half), .error_out_ivc(eivc_half), .error_type_out(etype_half));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic h, input logic t, input int vc);
        flit_valid_in   = v;
        flit_head_in    = v & h;
        flit_tail_in    = v & t;
        flit_sel_in_ivc = v ? (NV'(1) << vc) : '0;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0);
        enable      = 1'b0;
        clear_stats = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fc_full !== '0) begin errors++; $display("FAIL reset_fc got=%h exp=0", fc_full); end
        checks++; if (empty_full !== '1) begin errors++; $display("FAIL reset_empty got=%b exp=all ones", empty_full); end
        checks++; if (flits_full !== '0 || pkts_full !== '0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", flits_full, pkts_full); end
        checks++; if (eivc_full !== '0 || etype_full !== '0) begin errors++; $display("FAIL reset_errors got=%b/%b exp=0/0", eivc_full, etype_full); end
    endtask

    task automatic test_single_flit();
        do_reset();
        enable = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++; if (fc_full !== 4'b0000) begin errors++; $display("FAIL single_fc_early got=%b exp=0000", fc_full); end
        checks++; if (pkts_full !== 32'd1) begin errors++; $display("FAIL single_pkts got=%0d exp=1", pkts_full); end
        tick();
        checks++; if (fc_full !== 4'b1011) begin errors++; $display("FAIL single_credit got=%b exp=1011", fc_full); end
        checks++; if (flits_full !== 32'd1) begin errors++; $display("FAIL single_flits got=%0d exp=1", flits_full); end
        checks++; if (etype_full !== 4'd0 || eivc_full !== '0) begin errors++; $display("FAIL single_errors got=%b/%b exp=0/0", etype_full, eivc_full); end
        tick();
        checks++; if (fc_full !== 4'b0000) begin errors++; $display("FAIL single_fc_after got=%b exp=0000", fc_full); end
    endtask

    task automatic test_overflow();
        int n0;
        int nother;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, i == 0, 1'b0, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++; if (etype_full !== 4'b0001) begin errors++; $display("FAIL ovf_type got=%b exp=0001", etype_full); end
        checks++; if (eivc_full !== 8'h01) begin errors++; $display("FAIL ovf_ivc got=%b exp=00000001", eivc_full); end
        checks++; if (empty_full[0] !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", empty_full[0]); end
        enable = 1'b1;
        n0 = 0;
        nother = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fc_full[VW]) begin
                if (fc_full[VW-1:0] == 3'd0) n0++; else nother++;
            end
        end
        checks++; if (n0 != 8 || nother != 0) begin errors++; $display("FAIL ovf_credits got=%0d vc0 %0d other exp=8 vc0 0 other", n0, nother); end
        checks++; if (empty_full[0] !== 1'b1) begin errors++; $display("FAIL ovf_drained got=%b exp=1", empty_full[0]); end
    endtask

    task automatic test_rr_order();
        int vcs [3];
        int exp [6];
        vcs = '{1, 2, 5};
        exp = '{1, 2, 5, 1, 2, 5};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, 1'b1, 1'b1, vcs[j]);
                tick();
            end
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (fc_full !== {1'b1, 3'(exp[k])}) begin
                errors++; $display("FAIL rr_credit_%0d got=%b exp=%b", k, fc_full, {1'b1, 3'(exp[k])});
            end
        end
        tick();
        checks++; if (fc_full !== 4'b0000) begin errors++; $display("FAIL rr_idle got=%b exp=0000", fc_full); end
    endtask

    task automatic test_protocol_errors();
        logic [NV-1:0] exp_ivc;
        exp_ivc = (NV'(1) << 2) | (NV'(1) << 4);
        do_reset();
        enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2); tick();
        drive(1'b1, 1'b1, 1'b0, 2); tick();
        drive(1'b1, 1'b0, 1'b0, 4); tick();
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++; if (etype_full !== 4'b0110) begin errors++; $display("FAIL proto_type got=%b exp=0110", etype_full); end
        checks++; if (eivc_full !== exp_ivc) begin errors++; $display("FAIL proto_ivc got=%b exp=%b", eivc_full, exp_ivc); end
        checks++; if (flits_full !== 32'd2 || pkts_full !== 32'd0) begin errors++; $display("FAIL proto_counts got=%0d/%0d exp=2/0", flits_full, pkts_full); end
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checks++; if (etype_full !== 4'd0 || eivc_full !== '0) begin errors++; $display("FAIL clear_errors got=%b/%b exp=0/0", etype_full, eivc_full); end
        checks++; if (flits_full !== 32'd0 || pkts_full !== 32'd0) begin errors++; $display("FAIL clear_counts got=%0d/%0d exp=0/0", flits_full, pkts_full); end
        checks++; if (fc_full !== 4'b1100) begin errors++; $display("FAIL clear_credit got=%b exp=1100", fc_full); end
    endtask

    task automatic test_rate();
        int n_zero;
        int n_half;
        do_reset();
        for (int i = 0; i < NV * DEPTH; i++) begin
            drive(1'b1, 1'b1, 1'b1, i % NV);
            tick();
        end
        enable = 1'b1;
        n_zero = 0;
        n_half = 0;
        for (int c = 0; c < 4096; c++) begin
            drive(1'b1, 1'b1, 1'b1, c % NV);
            tick();
            if (fc_zero[VW]) n_zero++;
            if (fc_half[VW]) n_half++;
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++; if (n_zero != 0) begin errors++; $display("FAIL rate0_credits got=%0d exp=0", n_zero); end
        checks++; if (empty_zero !== '0) begin errors++; $display("FAIL rate0_backlog got=%b exp=00000000", empty_zero); end
        checks++; if (n_half < 1920 || n_half > 2176) begin errors++; $display("FAIL rate128_credits got=%0d exp=1920..2176", n_half); end
    endtask

    // Random legal traffic on the always-draining instance against a queue-level model.
    task automatic test_random();
        int occ [NV];
        bit in_pkt [NV];
        int pay [NV];
        int ptr;
        int exp_flits;
        int exp_pkts;
        int g;
        int vc;
        logic v, h, t, en;
        logic [VW:0] exp_fc;
        logic [NV-1:0] exp_empty;
        do_reset();
        for (int i = 0; i < NV; i++) begin occ[i] = 0; in_pkt[i] = 0; pay[i] = 0; end
        ptr = 0; exp_flits = 0; exp_pkts = 0;
        for (int c = 0; c < 800; c++) begin
            en = ($urandom_range(0, 9) != 0);
            vc = $urandom_range(0, NV - 1);
            v  = ($urandom_range(0, 1) == 1) && (occ[vc] < DEPTH);
            if (!in_pkt[vc]) begin
                h = 1'b1;
                t = ($urandom_range(0, 1) == 1);
            end else begin
                h = 1'b0;
                t = (pay[vc] + 1 >= MAXP) ? 1'b1 : ($urandom_range(0, 2) == 0);
            end
            enable = en;
            drive(v, h, t, vc);
            g = -1;
            if (en) begin
                for (int i = 0; i < NV; i++) begin
                    if (g < 0 && occ[(ptr + i) % NV] > 0) g = (ptr + i) % NV;
                end
            end
            if (g >= 0) begin occ[g]--; ptr = (g + 1) % NV; exp_flits++; end
            if (v) begin
                occ[vc]++;
                if (h) pay[vc] = 0; else pay[vc]++;
                in_pkt[vc] = !t;
                if (t) exp_pkts++;
            end
            tick();
            exp_fc = (g >= 0) ? {1'b1, 3'(g)} : 4'b0000;
            for (int i = 0; i < NV; i++) exp_empty[i] = (occ[i] == 0);
            checks++; if (fc_full !== exp_fc) begin errors++; $display("FAIL rand_fc cyc=%0d got=%b exp=%b", c, fc_full, exp_fc); end
            checks++; if (empty_full !== exp_empty) begin errors++; $display("FAIL rand_empty cyc=%0d got=%b exp=%b", c, empty_full, exp_empty); end
            checks++; if (flits_full !== SW'(exp_flits)) begin errors++; $display("FAIL rand_flits cyc=%0d got=%0d exp=%0d", c, flits_full, exp_flits); end
            checks++; if (pkts_full !== SW'(exp_pkts)) begin errors++; $display("FAIL rand_pkts cyc=%0d got=%0d exp=%0d", c, pkts_full, exp_pkts); end
            checks++; if (etype_full !== 4'd0) begin errors++; $display("FAIL rand_errors cyc=%0d got=%b exp=0000", c, etype_full); end
        end
        drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_len_check();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i == 0, i == 5, 1);
            tick();
`ifdef FLIT_SINK_CTRL_LEN_CHECK_EN
            if (i == 4) begin
                checks++; if (etype_full[3] !== 1'b0) begin errors++; $display("FAIL len_early got=%b exp=0", etype_full[3]); end
            end
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 0);
`ifdef FLIT_SINK_CTRL_LEN_CHECK_EN
        checks++; if (etype_full !== 4'b1000) begin errors++; $display("FAIL len_long_type got=%b exp=1000", etype_full); end
        checks++; if (eivc_full !== 8'h02) begin errors++; $display("FAIL len_long_ivc got=%b exp=00000010", eivc_full); end
`else
        checks++; if (etype_full !== 4'b0000) begin errors++; $display("FAIL len_disabled got=%b exp=0000", etype_full); end
`endif
        checks++; if (pkts_full !== 32'd1) begin errors++; $display("FAIL len_long_pkts got=%0d exp=1", pkts_full); end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, i == 4, 1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++; if (etype_full !== 4'b0000 || eivc_full !== '0) begin errors++; $display("FAIL len_ok got=%b/%b exp=0000/0", etype_full, eivc_full); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        clear_stats = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        test_reset();
        test_single_flit();
        test_overflow();
        test_rr_order();
        test_protocol_errors();
        test_rate();
        test_random();
        test_len_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
